// File: rtl/pc_branch_if.sv
// Sequencer-facing bundle for pc_branch: jump/call/return requests in, PC and stack status out.
interface pc_branch_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

  logic                inc;
  logic                jump_req;
  logic [2:0]          cond;
  logic [PC_WIDTH-1:0] target;
  logic [1:0]          flags;
  logic                err_clr;
  logic [PC_WIDTH-1:0] pc;
  logic                taken;
  logic                stack_err;
  logic [DepthW-1:0]   depth;

  modport master (
    output inc, jump_req, cond, target, flags, err_clr,
    input  pc, taken, stack_err, depth
  );

  modport slave (
    input  inc, jump_req, cond, target, flags, err_clr,
    output pc, taken, stack_err, depth
  );
endinterface

// File: rtl/pc_branch.sv
// SAP-2 program counter: conditional jumps on registered Z/S flags plus a small
// register-based return-address stack for CALL/RET.
module pc_branch #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  pc_branch_if.slave bus
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PtrW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DepthW-1:0] DepthFull = DepthW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    CondJmp  = 3'b000,
    CondJz   = 3'b001,
    CondJnz  = 3'b010,
    CondJm   = 3'b011,
    CondJp   = 3'b100,
    CondCall = 3'b101,
    CondRet  = 3'b110,
    CondRsvd = 3'b111
  } cond_e;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic                taken_q, taken_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                push;
  logic                err_set;
  logic                flag_z, flag_s;
  logic [PtrW-1:0]     push_idx, top_idx;

  assign flag_z   = bus.flags[1];
  assign flag_s   = bus.flags[0];
  // Push slot is the current depth; top of stack sits one below it.
  assign push_idx = PtrW'(depth_q);
  assign top_idx  = PtrW'(depth_q - DepthW'(1));

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    taken_d = 1'b0;
    push    = 1'b0;
    err_set = 1'b0;

    if (bus.jump_req) begin
      unique case (cond_e'(bus.cond))
        CondJmp: taken_d = 1'b1;
        CondJz:  taken_d = flag_z;
        CondJnz: taken_d = ~flag_z;
        CondJm:  taken_d = flag_s;
        CondJp:  taken_d = ~flag_s;
        CondCall: begin
          if (depth_q < DepthFull) begin
            push    = 1'b1;
            depth_d = depth_q + DepthW'(1);
            taken_d = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
        CondRet: begin
          if (depth_q != '0) begin
            depth_d = depth_q - DepthW'(1);
            pc_d    = stack_q[top_idx];
            taken_d = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
        CondRsvd: taken_d = 1'b0;
        default:  taken_d = 1'b0;
      endcase
      // RET already loaded pc_d from the stack; every other taken case goes to target.
      if (taken_d && (cond_e'(bus.cond) != CondRet)) begin
        pc_d = bus.target;
      end
    end else if (bus.inc) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end

    // A fresh overflow/underflow wins over a same-cycle clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      depth_q <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; depth alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_q[push_idx] <= pc_q;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.taken     = taken_q;
  assign bus.stack_err = err_q;
  assign bus.depth     = depth_q;

endmodule

// File: doc/pc_branch.md
# pc_branch

Program counter with conditional branch evaluation and a small hardware return-address stack for the SAP-2 datapath. It sits directly downstream of the flags register. It consumes the registered Z/S flag pair, evaluates the condition field of a jump/call/return request from the control sequencer, and produces the next instruction address for the memory address register.

## Interface
- PC_WIDTH, 16, width of program counter, branch target and stack entries
- STACK_DEPTH, 4, number of return-address entries (≥1)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- inc  input  1  increment PC by 1
- jump_req  input  1  evaluate cond this cycle; overrides inc
- cond  input  3  000 JMP, 001 JZ, 010 JNZ, 011 JM, 100 JP, 101 CALL, 110 RET, 111 reserved
- target  input  PC_WIDTH  branch/call destination
- flags  input  2  bit1 = Z, bit0 = S (flags block output format)
- err_clr  input  1  clear stack_err
- pc  output  PC_WIDTH  current program counter
- taken  output  1  one-cycle pulse: previous-cycle jump_req was taken
- stack_err  output  1  sticky overflow/underflow indicator
- depth  output  $clog2(STACK_DEPTH+1)  occupied stack entries

## Operation
- Reset values (rst high at posedge): pc=0, taken=0, stack_err=0, depth=0. Stack contents are don't-care.
- Priority per cycle: rst > jump_req > inc > hold.
- Condition evaluation uses flags sampled at the same posedge as jump_req. The flags block updates on negedge, so flags are stable.
- JMP: always taken, pc←target.
- JZ: taken if Z=1. JNZ: taken if Z=0. JM: taken if S=1. JP: taken if S=0. Taken means pc←target.
- Not taken: pc holds. inc is ignored in a jump_req cycle; the sequencer has already stepped past operands.
- CALL with depth<STACK_DEPTH: push current pc, depth+1, pc←target, taken.
- CALL with depth=STACK_DEPTH (overflow): no push, pc holds, stack_err←1, not taken.
- RET with depth>0: pc←top entry, depth−1, taken.
- RET with depth=0 (underflow): pc holds, stack_err←1, not taken.
- cond=111: treated as not taken, no state change except taken←0.
- inc alone: pc←pc+1 modulo 2^PC_WIDTH; 0xFFFF wraps to 0x0000.
- err_clr: stack_err←0, unless a new overflow/underflow occurs the same cycle, in which case set wins.
- Stack is LIFO, register-based, top index = depth−1. Entries above depth are never read.

## Timing
- pc, depth and stack_err are registered. The new value is visible the cycle after the request edge (latency 1).
- taken is registered and high for exactly the cycle following a taken request. Back-to-back taken requests keep it high continuously.
- Back-to-back CALL/RET on consecutive cycles are supported. A RET immediately after a CALL returns the pc that was pushed.
- rst asserted mid-sequence (any cycle) discards the stack: depth=0, pc=0 the next cycle regardless of jump_req/inc.
- No combinational path from inputs to outputs.

## Test plan
- Reset then inc for 3 cycles → pc 0,1,2,3. Preload pc=0xFFFF via JMP, then inc → pc=0x0000.
- flags=2'b10, jump_req cond=001 target=0x1234 → pc=0x1234, taken=1 for one cycle. Same request with flags=2'b00 → pc unchanged, taken=0.
- JNZ/JM/JP at all four flag combinations → taken matches truth table. Simultaneous inc with a not-taken request → pc unchanged.
- At pc=0x0010: CALL 0x0100, then CALL 0x0200 → depth=2. RET → pc=0x0100, depth=1. RET → pc=0x0010, depth=0.
- 5 CALLs with STACK_DEPTH=4 → 5th leaves pc at previous target, stack_err=1, depth=4. RET at depth 0 → stack_err=1, pc holds. err_clr → stack_err=0.
- Assert rst with depth=3 during a CALL → next cycle pc=0, depth=0, taken=0. Subsequent RET → underflow.
